// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the 4x4 keypad row-scan controller.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;
  typedef enum logic {ARMED, LATCHED} db_phase_t;

  function automatic logic [2:0] count_low(input logic [COLS-1:0] col_n);
    logic [2:0] n;
    n = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_n[c]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Lowest-numbered active column; only meaningful when exactly one is low.
  function automatic logic [1:0] first_low(input logic [COLS-1:0] col_n);
    logic [1:0] idx;
    idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_n[c]) idx = 2'(c);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller bus: row decoder drive, column sense and key handshake.
interface keypad_scan_if;

  logic                            scan_en;
  logic [keypad_pkg::COLS-1:0]     col_n;
  logic                            dec_a;
  logic                            dec_b;
  logic                            dec_e;
  logic                            key_valid;
  logic                            key_ready;
  keypad_pkg::key_code_t           key_code;
  logic                            overrun;

  modport master (
    input  scan_en, col_n, key_ready,
    output dec_a, dec_b, dec_e, key_valid, key_code, overrun
  );

  modport slave (
    output scan_en, col_n, key_ready,
    input  dec_a, dec_b, dec_e, key_valid, key_code, overrun
  );

endinterface

// File: rtl/keypad_scan_ctrl_debounce.sv
// Scan-to-scan debouncer: accepts a single key after DEBOUNCE_CNT identical
// scans, then waits for DEBOUNCE_CNT empty scans before re-arming.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clear,
  input  logic      i_scan_done,
  input  scan_res_t i_result,
  input  key_code_t i_code,
  output logic      o_emit,
  output key_code_t o_code
);

  localparam int CW = $clog2(DEBOUNCE_CNT) + 1;

  db_phase_t   r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_inc;
  key_code_t   r_code, w_code_nxt;

  assign w_inc  = r_cnt + CW'(1);
  assign o_code = i_code;

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    o_emit      = 1'b0;
    if (i_clear) begin
      w_phase_nxt = ARMED;
      w_cnt_nxt   = '0;
    end else if (i_scan_done) begin
      case (r_phase)
        ARMED: begin
          if (i_result == SINGLE) begin
            w_code_nxt = i_code;
            if (r_cnt != '0 && i_code == r_code) w_cnt_nxt = w_inc;
            else                                 w_cnt_nxt = CW'(1);
            if (w_cnt_nxt == CW'(DEBOUNCE_CNT)) begin
              o_emit      = 1'b1;
              w_phase_nxt = LATCHED;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        LATCHED: begin
          // Any key activity, even a chord, restarts the release window.
          if (i_result == NONE) begin
            w_cnt_nxt = w_inc;
            if (w_cnt_nxt == CW'(DEBOUNCE_CNT)) begin
              w_phase_nxt = ARMED;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_phase_nxt = ARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= ARMED;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad row sequencer for a 2x4 active-low decoder with column sampling,
// scan classification and a valid/ready key output.
//   state | meaning
//   IDLE  | decoder disabled, waiting for scan_en
//   DRIVE | one row enabled, held SETTLE_CYCLES+1 cycles, sampled on the last
//   EVAL  | decoder disabled one cycle, scan result handed to the debouncer
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEBOUNCE_CNT  = 3
) (
  input  logic clk,
  input  logic rst_n,
  keypad_scan_if.master kp
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_row;
  logic [SW-1:0] r_settle;
  logic [1:0]    r_nkeys;
  key_code_t     r_scan_code;
  logic          r_key_valid;
  key_code_t     r_key_code;
  logic          r_overrun;

  logic          w_sample;
  logic          w_abort;
  logic [2:0]    w_row_cnt;
  logic [2:0]    w_sum;
  scan_res_t     w_result;
  logic          w_emit;
  key_code_t     w_emit_code;
  logic          w_accept;

  assign w_sample  = (r_state == DRIVE) && kp.scan_en && (r_settle == '0);
  assign w_abort   = (r_state == DRIVE) && !kp.scan_en;
  assign w_row_cnt = count_low(kp.col_n);
  assign w_sum     = {1'b0, r_nkeys} + w_row_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (kp.scan_en) w_state_nxt = DRIVE;
      DRIVE: begin
        if (!kp.scan_en)                       w_state_nxt = IDLE;
        else if (w_sample && r_row == 2'd3)    w_state_nxt = EVAL;
      end
      EVAL:    w_state_nxt = kp.scan_en ? DRIVE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Key count saturates at 2: only none/one/many matters for classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_settle    <= SW'(SETTLE_CYCLES);
      r_nkeys     <= '0;
      r_scan_code <= '0;
    end else if (r_state == DRIVE) begin
      if (w_sample) begin
        r_settle <= SW'(SETTLE_CYCLES);
        if (r_row != 2'd3) r_row <= r_row + 2'd1;
        r_nkeys  <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        if (r_nkeys == 2'd0 && w_row_cnt == 3'd1)
          r_scan_code <= {r_row, first_low(kp.col_n)};
      end else if (r_settle != '0) begin
        r_settle <= r_settle - SW'(1);
      end
    end else begin
      r_row    <= '0;
      r_settle <= SW'(SETTLE_CYCLES);
      r_nkeys  <= '0;
    end
  end

  always_comb begin
    case (r_nkeys)
      2'd0:    w_result = NONE;
      2'd1:    w_result = SINGLE;
      default: w_result = MULTI;
    endcase
  end

  keypad_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_abort),
    .i_scan_done (r_state == EVAL),
    .i_result    (w_result),
    .i_code      (r_scan_code),
    .o_emit      (w_emit),
    .o_code      (w_emit_code)
  );

  assign w_accept = r_key_valid && kp.key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_emit) begin
        if (!r_key_valid || w_accept) begin
          r_key_valid <= 1'b1;
          r_key_code  <= w_emit_code;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign kp.dec_e     = (r_state != DRIVE);
  assign kp.dec_a     = (r_state == DRIVE) && r_row[1];
  assign kp.dec_b     = (r_state == DRIVE) && r_row[0];
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomised and directed bench for keypad_scan_ctrl against a scan-level model.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SETTLE  = 2;
  localparam int DEB     = 3;
  localparam int H       = SETTLE + 1;
  localparam int EVAL_PH = 4 * H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_scan_if kp();

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_CNT(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  // Physical keypad: a pressed key pulls its column low while its row is enabled.
  logic [15:0] mask;
  logic [3:0]  w_col;
  always_comb begin
    w_col = 4'hF;
    if (!kp.dec_e)
      for (int c = 0; c < 4; c++)
        if (mask[{kp.dec_a, kp.dec_b, 2'(c)}]) w_col[c] = 1'b0;
  end
  assign kp.col_n = w_col;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ovr = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position, keys seen this scan, debounce and handshake.
  bit          m_en;
  int          m_phase;
  logic [15:0] m_seen;
  bit          m_latched;
  int          m_cnt;
  int          m_last;
  bit          m_valid;
  logic [3:0]  m_code;
  bit          m_ovr;

  task automatic model_reset();
    m_en = 0; m_phase = 0; m_seen = '0;
    m_latched = 0; m_cnt = 0; m_last = 0;
    m_valid = 0; m_code = '0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit emit;
    int code;
    int nk;
    acc  = m_valid && kp.key_ready;
    emit = 0;
    code = 0;
    if (!m_en) begin
      if (kp.scan_en) begin m_en = 1; m_phase = 0; m_seen = '0; end
    end else if (m_phase < EVAL_PH) begin
      if (!kp.scan_en) begin
        m_en = 0; m_latched = 0; m_cnt = 0;
      end else begin
        if (m_phase % H == H - 1)
          for (int c = 0; c < 4; c++)
            m_seen[(m_phase / H) * 4 + c] = mask[(m_phase / H) * 4 + c];
        m_phase++;
      end
    end else begin
      nk = $countones(m_seen);
      for (int k = 0; k < 16; k++) if (m_seen[k]) code = k;
      if (!m_latched) begin
        if (nk == 1) begin
          m_cnt  = (m_cnt > 0 && code == m_last) ? m_cnt + 1 : 1;
          m_last = code;
          if (m_cnt == DEB) begin emit = 1; m_latched = 1; m_cnt = 0; end
        end else m_cnt = 0;
      end else begin
        if (nk == 0) begin
          m_cnt++;
          if (m_cnt == DEB) begin m_latched = 0; m_cnt = 0; end
        end else m_cnt = 0;
      end
      if (kp.scan_en) begin m_phase = 0; m_seen = '0; end
      else m_en = 0;
    end
    m_ovr = 0;
    if (emit) begin
      if (!m_valid || acc) begin m_valid = 1; m_code = 4'(code); end
      else m_ovr = 1;
    end else if (acc) m_valid = 0;
  endtask

  task automatic cycle();
    bit e;
    int ab;
    @(negedge clk);
    e  = !(m_en && m_phase < EVAL_PH);
    ab = e ? 0 : m_phase / H;
    chk("dec_e",     8'(kp.dec_e),              8'(e));
    chk("dec_row",   8'({kp.dec_a, kp.dec_b}),  8'(ab));
    chk("key_valid", 8'(kp.key_valid),          8'(m_valid));
    chk("key_code",  8'(kp.key_code),           8'(m_code));
    chk("overrun",   8'(kp.overrun),            8'(m_ovr));
    if (kp.key_valid && kp.key_ready) n_acc++;
    if (kp.overrun) n_ovr++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scans(input int n);
    int done = 0;
    int budget = 0;
    while (done < n && budget < 40 * n) begin
      if (m_en && m_phase == EVAL_PH) done++;
      cycle();
      budget++;
    end
    chk("scans_done", 8'(done), 8'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dec_e"},  8'(kp.dec_e),                 8'd1);
    chk({tag, "_dec_ab"}, 8'({kp.dec_a, kp.dec_b}),     8'd0);
    chk({tag, "_valid"},  8'(kp.key_valid),             8'd0);
    chk({tag, "_code"},   8'(kp.key_code),              8'd0);
    chk({tag, "_ovr"},    8'(kp.overrun),               8'd0);
  endtask

  int n0;
  int idle_left;
  int r;
  int b0, b1;
  int budget;

  initial begin
    rst_n = 1'b0;
    kp.scan_en = 1'b0;
    kp.key_ready = 1'b0;
    mask = '0;
    model_reset();
    #12;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequencing with no keys
    kp.scan_en = 1'b1; kp.key_ready = 1'b1;
    run_scans(2);
    chk("idle_no_key", 8'(n_acc), 8'd0);

    // Press key (2,1), hold, release, press again
    mask = 16'(1) << 9;  run_scans(8);
    chk("press1_emits", 8'(n_acc), 8'd1);
    mask = '0;           run_scans(4);
    mask = 16'(1) << 9;  run_scans(5);
    chk("press2_emits", 8'(n_acc), 8'd2);

    // Two keys in row 1
    mask = (16'(1) << 4) | (16'(1) << 7);
    run_scans(10);
    chk("multi_no_emit", 8'(n_acc), 8'd2);

    // Backpressure and overrun
    mask = '0;           run_scans(4);
    kp.key_ready = 1'b0;
    mask = 16'(1) << 9;  run_scans(4);
    mask = '0;           run_scans(4);
    mask = 16'(1);       run_scans(4);
    chk("bp_overrun_cnt", 8'(n_ovr), 8'd1);
    chk("bp_code_kept",   8'(kp.key_code), 8'h9);
    chk("bp_valid_held",  8'(kp.key_valid), 8'd1);
    kp.key_ready = 1'b1;
    cycle(); cycle();
    chk("bp_valid_drop",  8'(kp.key_valid), 8'd0);

    // Abort mid-scan clears the debounce count
    mask = '0;           run_scans(4);
    mask = 16'(1) << 9;  run_scans(2);
    budget = 0;
    while (!(m_en && m_phase == H + 1) && budget < 50) begin cycle(); budget++; end
    chk("reach_row1", 8'(m_phase), 8'(H + 1));
    kp.scan_en = 1'b0;
    cycle(); cycle();
    chk("abort_dec_e", 8'(kp.dec_e), 8'd1);
    kp.scan_en = 1'b1;
    n0 = n_acc;
    run_scans(2);
    chk("abort_no_early", 8'(n_acc), 8'(n0));
    run_scans(1);
    cycle();
    chk("abort_fresh_emit", 8'(n_acc), 8'(n0 + 1));

    // Random traffic
    idle_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ((!m_en || m_phase == EVAL_PH) && $urandom_range(2) == 0) begin
        r = $urandom_range(9);
        if (r < 4)      mask = '0;
        else if (r < 8) mask = 16'(1) << $urandom_range(15);
        else begin
          b0 = $urandom_range(15);
          b1 = (b0 + 1 + $urandom_range(14)) % 16;
          mask = (16'(1) << b0) | (16'(1) << b1);
        end
      end
      kp.key_ready = ($urandom_range(3) != 0);
      if (idle_left > 0) begin
        idle_left--; kp.scan_en = 1'b0;
      end else if ($urandom_range(299) == 0) begin
        idle_left = $urandom_range(15, 1); kp.scan_en = 1'b0;
      end else kp.scan_en = 1'b1;
      cycle();
    end

    // Asynchronous reset with a key pending
    kp.scan_en = 1'b1; kp.key_ready = 1'b0;
    mask = '0;           run_scans(4);
    mask = 16'(1) << 9;  run_scans(4);
    chk("pre_rst_valid", 8'(kp.key_valid), 8'd1);
    cycle(); cycle(); cycle(); cycle(); cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mask = '0;
    run_scans(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
